// File: rtl/sram_access_sequencer.sv
// -----------------------------------------------------------------------------
// sram_access_sequencer
//
// Memory-stage controller that turns a 32-bit pipeline load/store into two
// half-word accesses on an external 16-bit SRAM: low half-word first, then
// high half-word. Each phase holds the SRAM pins steady for WAIT_CYCLES clocks.
// While an access is in flight, ready is low, and the pipeline freezes on ~ready.
//
// Parameters
//   BASE_ADDR    byte address that maps to SRAM half-word 0
//   SRAM_AW      SRAM half-word address width
//   WAIT_CYCLES  clocks per half-word phase (>= 1)
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous, active-high reset
//   mem_read     load request, level, held until ready
//   mem_write    store request, level, held until ready (ignored if mem_read)
//   address      word-aligned byte address
//   write_data   store data
//   read_data    load data, valid while ready=1 in DONE
//   ready        1 = no stall, 0 = pipeline must freeze (combinational)
//   addr_err     sticky out-of-range flag (0 unless range checking is built in)
//   sram_addr    SRAM half-word address
//   sram_we_n    SRAM write strobe, active low
//   sram_dq_out  data driven to the SRAM
//   sram_dq_oe   1 = drive sram_dq_out onto the SRAM bus
//   sram_dq_in   data returned by the SRAM
//
// Build option
//   SRAM_RANGE_CHECK_EN  When this macro is defined, requests below BASE_ADDR
//                        or beyond the SRAM are completed at once without any
//                        SRAM strobe. A load in that case returns 0, and
//                        addr_err is set until reset. When the macro is not
//                        defined, the address wraps by truncation and addr_err
//                        is tied to 0.
// -----------------------------------------------------------------------------
module sram_access_sequencer #(
  parameter int unsigned BASE_ADDR   = 1024,
  parameter int unsigned SRAM_AW     = 18,
  parameter int unsigned WAIT_CYCLES = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mem_read,
  input  logic               mem_write,
  input  logic [31:0]        address,
  input  logic [31:0]        write_data,
  output logic [31:0]        read_data,
  output logic               ready,
  output logic               addr_err,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic               sram_we_n,
  output logic [15:0]        sram_dq_out,
  output logic               sram_dq_oe,
  input  logic [15:0]        sram_dq_in
);

  // Word index width: one SRAM address bit selects the half-word.
  localparam int unsigned WW       = SRAM_AW - 1;
  localparam int unsigned CW       = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WAIT_CYCLES - 1);
  localparam logic [31:0]   BASE     = 32'(BASE_ADDR);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LO,
    S_HI,
    S_DONE
  } state_t;

  state_t          r_state;
  state_t          w_next_state;

  logic            r_op_write;
  logic [WW-1:0]   r_widx;
  logic [31:0]     r_wdata;
  logic [CW-1:0]   r_cnt;
  logic [31:0]     r_read_data;

  logic            w_req;
  logic            w_is_write;
  logic [31:0]     w_offset;
  logic [WW-1:0]   w_widx;
  logic            w_last;
  logic            w_out_of_range;

  assign w_req      = mem_read | mem_write;
  // A simultaneous read and write is treated as a read.
  assign w_is_write = mem_write & ~mem_read;
  assign w_offset   = address - BASE;
  // Truncation here gives the wrap-around behaviour when no range check is built in.
  assign w_widx     = WW'(w_offset >> 2);
  assign w_last     = (r_cnt == LAST_CNT);

`ifdef SRAM_RANGE_CHECK_EN
  // Below BASE the subtraction wraps, so that case must be tested on the raw address.
  assign w_out_of_range = (address < BASE) || ((w_offset >> 2) >= (32'd1 << WW));
`else
  assign w_out_of_range = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next_state;
  end

  // ---------------------------------------------------------------------------
  // Next state and SRAM pin decode
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output gets a default before the case, so no path leaves a
    // signal unassigned and no latch is inferred.
    w_next_state = r_state;
    ready        = 1'b0;
    sram_addr    = '0;
    sram_we_n    = 1'b1;
    sram_dq_out  = '0;
    sram_dq_oe   = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        // Combinational ready: it drops in the same cycle that a request appears.
        ready = ~w_req;
        if (w_req) w_next_state = w_out_of_range ? S_DONE : S_LO;
      end

      S_LO: begin
        sram_addr = {r_widx, 1'b0};
        if (r_op_write) begin
          sram_we_n   = 1'b0;
          sram_dq_oe  = 1'b1;
          sram_dq_out = r_wdata[15:0];
        end
        if (w_last) w_next_state = S_HI;
      end

      S_HI: begin
        sram_addr = {r_widx, 1'b1};
        if (r_op_write) begin
          sram_we_n   = 1'b0;
          sram_dq_oe  = 1'b1;
          sram_dq_out = r_wdata[31:16];
        end
        if (w_last) w_next_state = S_DONE;
      end

      S_DONE: begin
        // The request still held here belongs to the retiring instruction.
        // Returning to IDLE without looking at it prevents a duplicate access.
        ready        = 1'b1;
        w_next_state = S_IDLE;
      end

      default: w_next_state = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Request latch, phase counter and read capture
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_op_write  <= 1'b0;
      r_widx      <= '0;
      r_wdata     <= '0;
      r_cnt       <= '0;
      r_read_data <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_req) begin
            r_op_write <= w_is_write;
            r_widx     <= w_widx;
            r_wdata    <= write_data;
            r_cnt      <= '0;
            if (w_out_of_range && !w_is_write) r_read_data <= '0;
          end
        end

        S_LO: begin
          if (w_last) begin
            r_cnt <= '0;
            if (!r_op_write) r_read_data[15:0] <= sram_dq_in;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end

        S_HI: begin
          if (w_last) begin
            r_cnt <= '0;
            if (!r_op_write) r_read_data[31:16] <= sram_dq_in;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end

        default: ;
      endcase
    end
  end

  assign read_data = r_read_data;

`ifdef SRAM_RANGE_CHECK_EN
  logic r_addr_err;

  // Sticky: only reset clears it.
  always_ff @(posedge clk) begin
    if (rst)                                           r_addr_err <= 1'b0;
    else if (r_state == S_IDLE && w_req && w_out_of_range) r_addr_err <= 1'b1;
  end

  assign addr_err = r_addr_err;
`else
  assign addr_err = 1'b0;
`endif

endmodule

// File: tb/tb_sram_access_sequencer.sv
// -----------------------------------------------------------------------------
// Testbench for sram_access_sequencer (WAIT_CYCLES=3, BASE_ADDR=1024).
// A behavioural 64-entry SRAM model answers reads and absorbs writes.
// A table of whole-access vectors is followed by hand-written sequences:
// back-to-back access, reset in the middle of an access, and the optional
// out-of-range behaviour.
// -----------------------------------------------------------------------------
module tb_sram_access_sequencer;

  localparam int unsigned W = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        ready;
  logic        addr_err;
  logic [17:0] sram_addr;
  logic        sram_we_n;
  logic [15:0] sram_dq_out;
  logic        sram_dq_oe;
  logic [15:0] sram_dq_in;

  sram_access_sequencer #(
    .BASE_ADDR  (1024),
    .SRAM_AW    (18),
    .WAIT_CYCLES(W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .address    (address),
    .write_data (write_data),
    .read_data  (read_data),
    .ready      (ready),
    .addr_err   (addr_err),
    .sram_addr  (sram_addr),
    .sram_we_n  (sram_we_n),
    .sram_dq_out(sram_dq_out),
    .sram_dq_oe (sram_dq_oe),
    .sram_dq_in (sram_dq_in)
  );

  always #5 clk = ~clk;

  // Simple SRAM model. It aliases on the low 6 address bits.
  logic [15:0] sram_mem [0:63];
  logic        preload;

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 64; i++) sram_mem[i] <= 16'h0000;
      sram_mem[4] <= 16'hBEEF;
      sram_mem[5] <= 16'hDEAD;
    end else if (!sram_we_n) begin
      sram_mem[sram_addr[5:0]] <= sram_dq_out;
    end
  end

  assign sram_dq_in = sram_mem[sram_addr[5:0]];

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    string       name;
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [17:0] lo_addr;   // expected low-phase SRAM address
    logic        is_wr;     // expected to strobe the SRAM
    logic [31:0] rdata;     // expected read_data in DONE
  } vec_t;

  function automatic vec_t mk(input string name, input logic rd, input logic wr,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [17:0] lo_addr, input logic is_wr,
                              input logic [31:0] rdata);
    vec_t v;
    v.name = name; v.rd = rd; v.wr = wr; v.addr = addr; v.wdata = wdata;
    v.lo_addr = lo_addr; v.is_wr = is_wr; v.rdata = rdata;
    return v;
  endfunction

  // The task is called 1 time unit after a rising edge, with the DUT in IDLE.
  // It drives the request and checks every cycle until DONE. If hold is 0,
  // it then releases the request and checks the return to IDLE.
  task automatic do_access(input vec_t v, input bit hold);
    logic [17:0] exp_addr;
    logic [15:0] exp_dq;
    mem_read   = v.rd;
    mem_write  = v.wr;
    address    = v.addr;
    write_data = v.wdata;
    #1;
    check({v.name, " ready on request"}, 32'(ready), 32'd0);
    for (int c = 1; c <= 2 * W; c++) begin
      @(posedge clk); #1;
      exp_addr = (c <= W) ? v.lo_addr : v.lo_addr + 18'd1;
      exp_dq   = !v.is_wr ? 16'h0000 : (c <= W) ? v.wdata[15:0] : v.wdata[31:16];
      check($sformatf("%s c%0d sram_addr", v.name, c), 32'(sram_addr), 32'(exp_addr));
      check($sformatf("%s c%0d we_n", v.name, c), 32'(sram_we_n), 32'(!v.is_wr));
      check($sformatf("%s c%0d oe", v.name, c), 32'(sram_dq_oe), 32'(v.is_wr));
      check($sformatf("%s c%0d dq_out", v.name, c), 32'(sram_dq_out), 32'(exp_dq));
      check($sformatf("%s c%0d ready", v.name, c), 32'(ready), 32'd0);
    end
    @(posedge clk); #1;
    check({v.name, " done ready"}, 32'(ready), 32'd1);
    check({v.name, " done read_data"}, read_data, v.rdata);
    check({v.name, " done we_n"}, 32'(sram_we_n), 32'd1);
    if (!hold) begin
      mem_read  = 1'b0;
      mem_write = 1'b0;
      @(posedge clk); #1;
      check({v.name, " idle ready"}, 32'(ready), 32'd1);
      check({v.name, " idle read_data"}, read_data, v.rdata);
    end
  endtask

  vec_t vecs[$];

  initial begin
    rst = 1'b1; preload = 1'b1;
    mem_read = 1'b0; mem_write = 1'b0; address = '0; write_data = '0;

    vecs.push_back(mk("rd1032",  1, 0, 32'd1032, 32'h0,        18'd4,       0, 32'hDEADBEEF));
    vecs.push_back(mk("wr1024",  0, 1, 32'd1024, 32'h12345678, 18'd0,       1, 32'hDEADBEEF));
    vecs.push_back(mk("rd1024",  1, 0, 32'd1024, 32'h0,        18'd0,       0, 32'h12345678));
    vecs.push_back(mk("both1032",1, 1, 32'd1032, 32'hFFFFFFFF, 18'd4,       0, 32'hDEADBEEF));
    vecs.push_back(mk("wr1040",  0, 1, 32'd1040, 32'hCAFEF00D, 18'd8,       1, 32'hDEADBEEF));
    vecs.push_back(mk("rd1040",  1, 0, 32'd1040, 32'h0,        18'd8,       0, 32'hCAFEF00D));
`ifndef SRAM_RANGE_CHECK_EN
    // (512-1024)>>2 truncated to 17 bits = 0x1FF80 -> half-word 0x3FF00 (aliases to model[0]).
    vecs.push_back(mk("wrap512", 1, 0, 32'd512,  32'h0,        18'h3FF00,   0, 32'h12345678));
`endif

    // Reset held for two cycles.
    @(posedge clk); @(posedge clk); #1;
    check("reset ready", 32'(ready), 32'd1);
    check("reset read_data", read_data, 32'd0);
    check("reset we_n", 32'(sram_we_n), 32'd1);
    check("reset oe", 32'(sram_dq_oe), 32'd0);
    check("reset addr_err", 32'(addr_err), 32'd0);
    check("reset sram_addr", 32'(sram_addr), 32'd0);
    rst = 1'b0; preload = 1'b0;
    @(posedge clk); #1;

    foreach (vecs[i]) do_access(vecs[i], 1'b0);

    // Back-to-back: the request is still high through DONE, and there is
    // one IDLE cycle with ready low before the next access starts.
    do_access(vecs[0], 1'b1);
    @(posedge clk); #1;
    check("b2b idle ready", 32'(ready), 32'd0);
    check("b2b idle sram_addr", 32'(sram_addr), 32'd0);
    check("b2b idle we_n", 32'(sram_we_n), 32'd1);
    do_access(vecs[5], 1'b0);

    // Reset during the second cycle of the high phase.
    mem_read = 1'b1; mem_write = 1'b0; address = 32'd1032;
    repeat (W + 2) begin @(posedge clk); #1; end
    check("midrst hi sram_addr", 32'(sram_addr), 32'd5);
    rst = 1'b1; mem_read = 1'b0;
    @(posedge clk); #1;
    check("midrst ready", 32'(ready), 32'd1);
    check("midrst we_n", 32'(sram_we_n), 32'd1);
    check("midrst read_data", read_data, 32'd0);
    check("midrst sram_addr", 32'(sram_addr), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("midrst still idle read_data", read_data, 32'd0);
    do_access(vecs[5], 1'b0);

`ifdef SRAM_RANGE_CHECK_EN
    // An out-of-range load completes on the next cycle without an SRAM strobe.
    mem_read = 1'b1; address = 32'd512;
    #1;
    check("oor ready on request", 32'(ready), 32'd0);
    @(posedge clk); #1;
    check("oor done ready", 32'(ready), 32'd1);
    check("oor read_data", read_data, 32'd0);
    check("oor addr_err", 32'(addr_err), 32'd1);
    check("oor we_n", 32'(sram_we_n), 32'd1);
    check("oor oe", 32'(sram_dq_oe), 32'd0);
    check("oor sram_addr", 32'(sram_addr), 32'd0);
    mem_read = 1'b0;
    @(posedge clk); #1;
    check("oor idle ready", 32'(ready), 32'd1);
    do_access(vecs[2], 1'b0);
    check("oor addr_err sticky", 32'(addr_err), 32'd1);
`else
    check("addr_err tied low", 32'(addr_err), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
